// File: rtl/spart_pkg.sv
// Types and fixed addresses shared by the CPU-side SPART MMIO bridge.
package spart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        GAP
    } state_t;

    localparam logic [27:0] SPART_DATA_ADDR = 28'h800_0000;
    localparam logic [27:0] SPART_STAT_ADDR = 28'h800_0001;
    localparam logic [31:0] TO_RDATA        = 32'hDEAD_BEEF;

endpackage

// File: rtl/spart_mmio_bridge_if.sv
// SPART-side request/response bus: the bridge drives a request, SPART answers with ready/data.
interface spart_mmio_bridge_if #(
    parameter int unsigned ADDR_W = 28,
    parameter int unsigned DATA_W = 32
);
    logic              io_valid_data;
    logic              io_rw_data;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] io_wr_data;
    logic              io_ready_data;
    logic [DATA_W-1:0] io_rd_data;

    modport master (
        output io_valid_data, io_rw_data, mem_addr, io_wr_data,
        input  io_ready_data, io_rd_data
    );

    modport slave (
        input  io_valid_data, io_rw_data, mem_addr, io_wr_data,
        output io_ready_data, io_rd_data
    );
endinterface

// File: rtl/spart_mmio_bridge.sv
// Turns CPU loads/stores that hit the SPART window into one held SPART transaction,
// stalling the CPU until it completes or times out, then forcing a valid-low gap.
module spart_mmio_bridge
    import spart_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 28,
    parameter int unsigned       DATA_W   = 32,
    parameter logic [ADDR_W-1:0] IO_BASE  = ADDR_W'(SPART_DATA_ADDR),
    parameter int unsigned       IO_SPAN  = 2,
    parameter int unsigned       TIMEOUT  = 1023,
    parameter logic [DATA_W-1:0] TO_RDATA = DATA_W'(spart_pkg::TO_RDATA)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              cpu_done,
    output logic              timeout_err,
    input  logic              err_clr,
    spart_mmio_bridge_if.master io
);

    localparam int unsigned       CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_END = CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] IO_END  = IO_BASE + ADDR_W'(IO_SPAN);

    state_t            state;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_we;
    logic [CNT_W-1:0]  cnt;
    logic              valid_q;
    logic              hit;

    assign hit = cpu_req && (cpu_addr >= IO_BASE) && (cpu_addr < IO_END);

    assign cpu_stall        = (state == REQ) || ((state == IDLE) && hit);
    assign io.io_valid_data = valid_q;
    assign io.io_rw_data    = lat_we;
    assign io.mem_addr      = lat_addr;
    assign io.io_wr_data    = lat_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            lat_we      <= 1'b0;
            cnt         <= '0;
            valid_q     <= 1'b0;
            cpu_done    <= 1'b0;
            cpu_rdata   <= '0;
            timeout_err <= 1'b0;
        end else begin
            cpu_done <= 1'b0;
            if (err_clr) timeout_err <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (hit) begin
                        lat_addr  <= cpu_addr;
                        lat_wdata <= cpu_wdata;
                        lat_we    <= cpu_we;
                        cnt       <= '0;
                        valid_q   <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    cnt <= cnt + CNT_W'(1);
                    // Ready is tested first so a response on the final counted cycle is not an error.
                    if (io.io_ready_data) begin
                        if (!lat_we) cpu_rdata <= io.io_rd_data;
                        valid_q  <= 1'b0;
                        cpu_done <= 1'b1;
                        state    <= GAP;
                    end else if (cnt == CNT_END) begin
                        if (!lat_we) cpu_rdata <= TO_RDATA;
                        timeout_err <= 1'b1;
                        valid_q     <= 1'b0;
                        cpu_done    <= 1'b1;
                        state       <= GAP;
                    end
                end
                GAP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spart_mmio_bridge.sv
// Randomised check of spart_mmio_bridge against a transaction-level model of the bridge rules.
module tb_spart_mmio_bridge;
    import spart_pkg::*;

    localparam int unsigned TO     = 15;
    localparam logic [27:0] IO_BASE = SPART_DATA_ADDR;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [27:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        cpu_done;
    logic        timeout_err;
    logic        err_clr = 1'b0;

    spart_mmio_bridge_if #(.ADDR_W(28), .DATA_W(32)) io_if ();

    spart_mmio_bridge #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_stall   (cpu_stall),
        .cpu_done    (cpu_done),
        .timeout_err (timeout_err),
        .err_clr     (err_clr),
        .io          (io_if)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Model state: last load result and sticky error flag.
    logic [31:0] m_rdata = '0;
    logic        m_err   = 1'b0;

    // Length of the most recent valid-low run that ended with valid rising.
    int unsigned low_run = 0;
    int unsigned last_gap = 0;
    logic        prev_v = 1'b0;

    always @(negedge clk) begin
        if (io_if.io_valid_data === 1'b1) begin
            if (!prev_v) last_gap = low_run;
            low_run = 0;
        end else begin
            low_run++;
        end
        prev_v = io_if.io_valid_data;
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [27:0] miss_addr();
        logic [27:0] a;
        case ($urandom_range(0, 3))
            0: a = IO_BASE - 28'd1;
            1: a = IO_BASE + 28'd2;
            2: a = 28'h000_0100;
            default: begin
                a = 28'($urandom);
                if (a >= IO_BASE && a < IO_BASE + 28'd2) a = 28'h000_0100;
            end
        endcase
        return a;
    endfunction

    // Called at a negedge with the bridge in IDLE (or in GAP when in_gap is set);
    // returns at the negedge of the GAP cycle. SPART answers on the lat-th valid cycle.
    task automatic xact(input logic we, input logic [27:0] addr, input logic [31:0] wd,
                        input int unsigned lat, input logic [31:0] rd, input bit in_gap);
        int unsigned vcyc;
        int unsigned exp_v;
        bit          to;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        if (in_gap) begin
            #1 check_eq("gap_no_sample", 64'(cpu_stall), 64'(0));
            @(negedge clk);
        end
        #1 check_eq("hit_stall", 64'(cpu_stall), 64'(1));
        @(posedge clk);
        #1;
        cpu_req = 1'b0; cpu_we = 1'($urandom); cpu_addr = 28'($urandom); cpu_wdata = $urandom;
        vcyc = 0;
        @(negedge clk);
        while (io_if.io_valid_data === 1'b1 && vcyc < 40) begin
            vcyc++;
            check_eq("req_rw", 64'(io_if.io_rw_data), 64'(we));
            check_eq("req_addr", 64'(io_if.mem_addr), 64'(addr));
            check_eq("req_wdata", 64'(io_if.io_wr_data), 64'(wd));
            check_eq("req_stall", 64'(cpu_stall), 64'(1));
            check_eq("req_done", 64'(cpu_done), 64'(0));
            check_eq("req_rdata", 64'(cpu_rdata), 64'(m_rdata));
            if (vcyc == lat) begin
                io_if.io_ready_data = 1'b1;
                io_if.io_rd_data    = rd;
            end
            @(negedge clk);
            io_if.io_ready_data = 1'b0;
            io_if.io_rd_data    = $urandom;
        end
        to    = (lat > TO);
        exp_v = to ? TO : lat;
        if (!we) m_rdata = to ? TO_RDATA : rd;
        if (to) m_err = 1'b1;
        check_eq("valid_cycles", 64'(vcyc), 64'(exp_v));
        check_eq("gap_valid", 64'(io_if.io_valid_data), 64'(0));
        check_eq("gap_done", 64'(cpu_done), 64'(1));
        check_eq("gap_stall", 64'(cpu_stall), 64'(0));
        check_eq("gap_rdata", 64'(cpu_rdata), 64'(m_rdata));
        check_eq("gap_err", 64'(timeout_err), 64'(m_err));
    endtask

    // Starts in GAP; returns at an IDLE negedge with CPU inputs quiet.
    task automatic idle_cycles(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            bit clr;
            bit miss;
            @(negedge clk);
            check_eq("idle_valid", 64'(io_if.io_valid_data), 64'(0));
            check_eq("idle_done", 64'(cpu_done), 64'(0));
            check_eq("idle_err", 64'(timeout_err), 64'(m_err));
            check_eq("idle_rdata", 64'(cpu_rdata), 64'(m_rdata));
            clr  = ($urandom_range(0, 3) == 0);
            miss = 1'($urandom_range(0, 1));
            err_clr = clr; cpu_req = miss; cpu_we = 1'($urandom);
            cpu_addr = miss_addr(); cpu_wdata = $urandom;
            if (clr) m_err = 1'b0;
            #1 check_eq("miss_stall", 64'(cpu_stall), 64'(0));
        end
        @(negedge clk);
        check_eq("idle_valid", 64'(io_if.io_valid_data), 64'(0));
        check_eq("idle_done", 64'(cpu_done), 64'(0));
        check_eq("idle_err", 64'(timeout_err), 64'(m_err));
        err_clr = 1'b0; cpu_req = 1'b0;
    endtask

    initial begin
        io_if.io_ready_data = 1'b0;
        io_if.io_rd_data    = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_valid", 64'(io_if.io_valid_data), 64'(0));
        check_eq("rst_rw", 64'(io_if.io_rw_data), 64'(0));
        check_eq("rst_addr", 64'(io_if.mem_addr), 64'(0));
        check_eq("rst_wdata", 64'(io_if.io_wr_data), 64'(0));
        check_eq("rst_stall", 64'(cpu_stall), 64'(0));
        check_eq("rst_done", 64'(cpu_done), 64'(0));
        check_eq("rst_rdata", 64'(cpu_rdata), 64'(0));
        check_eq("rst_err", 64'(timeout_err), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // Status load, minimum latency: ready on 2nd REQ cycle
        xact(1'b0, SPART_STAT_ADDR, 32'h0, 2, 32'h0000_0003, 1'b0);
        check_eq("t1_rdata", 64'(cpu_rdata), 64'(32'h3));
        idle_cycles(1);

        // Store leaves cpu_rdata alone
        xact(1'b1, SPART_DATA_ADDR, 32'h0000_0041, 3, 32'h1234_5678, 1'b0);
        idle_cycles(2);

        // Back-to-back loads: the request held through GAP is taken in the next IDLE,
        // so the valid-low run is the GAP cycle plus that IDLE cycle.
        xact(1'b0, SPART_DATA_ADDR, 32'h0, 2, 32'hA5A5_0001, 1'b0);
        xact(1'b0, SPART_DATA_ADDR, 32'h0, 4, 32'hA5A5_0002, 1'b1);
        check_eq("b2b_gap", 64'(last_gap), 64'(2));
        idle_cycles(0);

        // Timeout, then explicit clear
        xact(1'b0, SPART_DATA_ADDR, 32'h0, 99, 32'h0, 1'b0);
        check_eq("to_err", 64'(timeout_err), 64'(1));
        check_eq("to_rdata", 64'(cpu_rdata), 64'(32'hDEAD_BEEF));
        @(negedge clk);
        err_clr = 1'b1; m_err = 1'b0;
        @(negedge clk);
        err_clr = 1'b0;
        check_eq("err_clr", 64'(timeout_err), 64'(0));

        // Out-of-window request is ignored
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 28'h000_0100;
        #1 check_eq("miss_stall_dir", 64'(cpu_stall), 64'(0));
        @(negedge clk);
        cpu_req = 1'b0;
        check_eq("miss_valid_dir", 64'(io_if.io_valid_data), 64'(0));

        // Ready on the same cycle the counter reaches TIMEOUT
        xact(1'b0, SPART_STAT_ADDR, 32'h0, TO, 32'h0000_00C3, 1'b0);
        check_eq("edge_no_err", 64'(timeout_err), 64'(0));
        idle_cycles(1);

        // Reset during the 2nd REQ cycle
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = SPART_DATA_ADDR;
        @(posedge clk);
        #1 cpu_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst6_valid_pre", 64'(io_if.io_valid_data), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_rdata = '0; m_err = 1'b0;
        check_eq("rst6_valid", 64'(io_if.io_valid_data), 64'(0));
        check_eq("rst6_stall", 64'(cpu_stall), 64'(0));
        check_eq("rst6_done", 64'(cpu_done), 64'(0));
        @(negedge clk);
        check_eq("rst6_idle_valid", 64'(io_if.io_valid_data), 64'(0));
        check_eq("rst6_idle_done", 64'(cpu_done), 64'(0));

        // Randomised traffic
        for (int unsigned k = 0; k < 60; k++) begin
            logic        we;
            logic [27:0] a;
            int unsigned lat;
            we  = 1'($urandom);
            a   = IO_BASE + 28'($urandom_range(0, 1));
            lat = $urandom_range(2, 18);
            xact(we, a, $urandom, lat, $urandom, 1'b0);
            if ($urandom_range(0, 3) == 0) begin
                we  = 1'($urandom);
                lat = $urandom_range(2, 18);
                xact(we, IO_BASE, $urandom, lat, $urandom, 1'b1);
                check_eq("b2b_gap_rand", 64'(last_gap), 64'(2));
            end
            idle_cycles($urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
